// File: rtl/max7219_chain.sv
// max7219_chain
// Serial driver for a daisy chain of N_DEV MAX7219 display drivers. One frame
// shifts one 16-bit word per device (farthest device first) while CS is held
// low, then raises CS so every device latches its word at the same time.
//
// Handshake: str is a level request, sampled only in IDLE. On acceptance busy
// rises, and it stays high until the frame (including the CS-high gap) is over.
// done pulses for one cycle in the first cycle with busy low. While busy is
// high, str, bcast, IRreg and data are ignored.
module max7219_chain #(
  parameter int Freq_MegaHZ = 50,
  parameter int Spi_KHz     = 1000,
  parameter int N_DEV       = 4
) (
  input  logic                 sys_clk,
  input  logic                 _rst,
  input  logic                 str,
  input  logic                 bcast,
  input  logic [8*N_DEV-1:0]   IRreg,
  input  logic [8*N_DEV-1:0]   data,
  output logic                 busy,
  output logic                 done,
  output logic                 CS,
  output logic                 CLK,
  output logic                 Din
);

  // sys_clk cycles per serial-clock half period, never below one
  localparam int DIV_RAW = (Freq_MegaHZ * 1000) / (2 * Spi_KHz);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NBITS   = 16 * N_DEV;
  localparam int BIT_W   = $clog2(NBITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_LATCH = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  load_word;
  logic              div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // Frame image: device k occupies bits [16k+15:16k], so the farthest device
  // sits in the MSBs and leaves first. Broadcast repeats the device-0 word.
  always_comb begin
    load_word = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (bcast)
        load_word[16*k +: 16] = {IRreg[7:0], data[7:0]};
      else
        load_word[16*k +: 16] = {IRreg[8*k +: 8], data[8*k +: 8]};
    end
  end

  // Frame sequencer: each bit is DIV cycles of CLK low then DIV cycles high,
  // followed by one DIV of CS low with CLK idle and one DIV of CS high.
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      CS      <= 1'b1;
      CLK     <= 1'b0;
      Din     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (str) begin
            shreg <= load_word;
            Din   <= load_word[NBITS-1];
            CS    <= 1'b0;
            busy  <= 1'b1;
            state <= S_LOW;
          end
        end
        S_LOW: begin
          if (div_end) begin
            div_cnt <= '0;
            CLK     <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (div_end) begin
            div_cnt <= '0;
            CLK     <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              // Din only moves on the CLK falling transition
              shreg   <= shreg << 1;
              Din     <= shreg[NBITS-2];
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= S_LOW;
            end else begin
              Din   <= 1'b0;
              state <= S_LATCH;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_LATCH: begin
          if (div_end) begin
            div_cnt <= '0;
            CS      <= 1'b1;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/max7219_chain.md
# max7219_chain

Parametrised successor to the single-device MAX7219 serial driver. Shifts one 16-bit word per device into a daisy chain of `N_DEV` MAX7219 display drivers in a single CS-low frame, with a programmable serial clock and a broadcast mode. It sits between the display-content sequencer, which issues `str` and advances on the falling edge of `busy`, and the physical CS/CLK/Din pins.

## Interface
- `Freq_MegaHZ`, 50: `sys_clk` frequency in MHz.
- `Spi_KHz`, 1000: target serial CLK frequency in kHz.
- `N_DEV`, 4: number of cascaded devices (≥1).
- Derived `DIV` = max(1, Freq_MegaHZ*1000 / (2*Spi_KHz)), integer division: `sys_clk` cycles per CLK half-period.

Ports:
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `_rst`  in  1  synchronous active-low reset.
- `str`  in  1  start request, level-sampled in IDLE.
- `bcast`  in  1  broadcast mode, sampled with `str`.
- `IRreg`  in  8*N_DEV  register address per device; slice [8k+7:8k] is for device k (device 0 is nearest the Din pin).
- `data`  in  8*N_DEV  register data per device, same slicing.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `CS`  out  1  chip select / LOAD, active low.
- `CLK`  out  1  serial clock, idles low.
- `Din`  out  1  serial data.

## Operation
- Reset (`_rst`=0 at a rising edge): state IDLE; `CS`=1, `CLK`=0, `Din`=0, `busy`=0, `done`=0; divider and bit counters cleared. Reset mid-frame aborts immediately. Devices may latch a partial word, and the sequencer must rewrite them.
- Frame word order: device N_DEV-1 first, device 0 last. Each word is {IRreg slice, data slice}, MSB first. Total `16*N_DEV` bits.
- `bcast`=1: every word is {IRreg[7:0], data[7:0]}. Upper slices are ignored.
- Inputs are captured into a `16*N_DEV`-bit shift register on acceptance. Input changes during `busy` have no effect.
- States:
  - IDLE: outputs at reset values. `str`=1 at an edge → capture, go to LOW, `busy`=1, `CS`=0, `Din`=first bit.
  - LOW: `CLK`=0, `Din` holds the current bit, for DIV cycles → HIGH.
  - HIGH: `CLK`=1 for DIV cycles. If the bit counter is below `16*N_DEV-1`: shift, increment the counter, `Din`=next bit, → LOW. Otherwise → LATCH.
  - LATCH: `CLK`=0, `CS`=0, `Din`=0 for DIV cycles → GAP with `CS`=1. The CS rising edge latches all devices.
  - GAP: `CS`=1 for DIV cycles (minimum CS-high time) → IDLE, `busy`=0, `done`=1 for one cycle.
- `Din` changes only on CLK falling transitions (LOW entry), so data is stable DIV cycles before each CLK rise.
- `str` is ignored while busy. If `str` is held high, the next frame is accepted on the first IDLE cycle. IDLE therefore lasts exactly one cycle between frames, with `done` and a fresh acceptance on the same edge.

## Timing
- Acceptance: `str` sampled high in IDLE at edge t. `busy`, `CS`=0 and first `Din` are valid after edge t.
- First CLK rise after edge t+DIV.
- Frame length, from `busy` rise to `busy` fall: DIV*(32*N_DEV + 2) cycles.
- `CS` low duration: DIV*(32*N_DEV + 1) cycles.
- Example: 50 MHz, 1000 kHz, N_DEV=4 gives DIV=25, 128 CLK pulses, `busy` for 3250 cycles.
- `done` is asserted in the cycle `busy` is first 0.

## Test plan
- N_DEV=1, DIV=2, IRreg=0x0C, data=0x01, str pulse → Din samples at 16 CLK rises = 0x0C01 MSB first; CS low 66 cycles; busy 68 cycles; one `done` pulse.
- N_DEV=4, IRreg={0x04,0x03,0x02,0x01}, data={0xDD,0xCC,0xBB,0xAA} → captured stream 0x04DD,0x03CC,0x02BB,0x01AA; 64 CLK rises, single CS rising edge.
- N_DEV=4, bcast=1, IRreg[7:0]=0x0A, data[7:0]=0x07, upper slices 0xFF → four words of 0x0A07.
- str re-pulsed mid-frame with changed IRreg/data → stream unchanged, frame length unchanged, no extra frame.
- `_rst`=0 during bit 5 → next edge CS=1, CLK=0, Din=0, busy=0; a following str starts a full new frame from bit 0.
- str held high for 3 frames, Freq_MegaHZ=50, Spi_KHz=1000 → busy low exactly 1 cycle between frames, coinciding with `done`, each frame 3250 cycles.
